// File: rtl/frame_update_arbiter.sv
// Vertical-blanking update scheduler: round-robin, one grant per clock, only inside vblank.
// Optional macro UPDATE_GUARD_EN stops grants GUARD_LINES lines before the end of the frame.
module frame_update_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_UPD     = 8,
    parameter int unsigned VL_TOTAL    = 628,
    parameter int unsigned GUARD_LINES = 2,
    localparam int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vblnk,
    input  logic [10:0]               vcount,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      upd_valid,
    output logic [ID_W-1:0]           upd_id,
    output logic [DATA_W-1:0]         upd_data,
    output logic                      window_open,
    output logic                      frame_start
);

    typedef enum logic [1:0] {
        StActive,
        StGrant,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic                vblnk_q;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          budget_q, budget_d;

    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                upd_valid_q, upd_valid_d;
    logic [ID_W-1:0]     upd_id_q, upd_id_d;
    logic [DATA_W-1:0]   upd_data_q, upd_data_d;
    logic                window_open_q, window_open_d;
    logic                frame_start_q, frame_start_d;

    logic [N_REQ-1:0]    eligible;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     win_idx;
    logic                win_found;
    logic                vblnk_rise;
    logic                guard_hit;

`ifdef UPDATE_GUARD_EN
    assign guard_hit = (32'(vcount) >= (VL_TOTAL - GUARD_LINES));
`else
    logic unused_vcount;
    assign unused_vcount = ^vcount;
    assign guard_hit     = 1'b0;
`endif

    assign vblnk_rise = vblnk & ~vblnk_q;

    // A requester whose ack is high this cycle has not yet had a chance to drop req.
    assign eligible = req & ~ack_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        budget_d    = budget_q;
        ack_d       = '0;
        upd_valid_d = 1'b0;
        upd_id_d    = upd_id_q;
        upd_data_d  = upd_data_q;

        unique case (state_q)
            StActive: begin
                if (vblnk_rise) begin
                    state_d  = StGrant;
                    budget_d = 8'(MAX_UPD);
                end
            end
            StGrant: begin
                if (!vblnk) begin
                    state_d = StActive;
                end else if (guard_hit || (budget_q == 8'd0)) begin
                    state_d = StHold;
                end else if (win_found) begin
                    ack_d[win_idx] = 1'b1;
                    upd_valid_d    = 1'b1;
                    upd_id_d       = win_idx;
                    upd_data_d     = req_data[32'(win_idx)*DATA_W +: DATA_W];
                    budget_d       = budget_q - 8'd1;
                    rr_ptr_d       = ID_W'((32'(win_idx) + 1) % N_REQ);
                    if (budget_q == 8'd1) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (!vblnk) begin
                    state_d = StActive;
                end
            end
            default: state_d = StActive;
        endcase

        window_open_d = (state_d == StGrant);
        frame_start_d = vblnk_q & ~vblnk;
    end

    // vblnk_q resets high so a vblank already in progress at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StActive;
            vblnk_q       <= 1'b1;
            rr_ptr_q      <= '0;
            budget_q      <= 8'd0;
            ack_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_id_q      <= '0;
            upd_data_q    <= '0;
            window_open_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vblnk_q       <= vblnk;
            rr_ptr_q      <= rr_ptr_d;
            budget_q      <= budget_d;
            ack_q         <= ack_d;
            upd_valid_q   <= upd_valid_d;
            upd_id_q      <= upd_id_d;
            upd_data_q    <= upd_data_d;
            window_open_q <= window_open_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ack         = ack_q;
    assign upd_valid   = upd_valid_q;
    assign upd_id      = upd_id_q;
    assign upd_data    = upd_data_q;
    assign window_open = window_open_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/frame_update_arbiter.md
# frame_update_arbiter

Vertical-blanking update scheduler for the shared game-state bus. Up to N_REQ game-logic requesters (duck position, crosshair, score, etc.) post parameter updates at any time. The block grants them one per clock, round-robin, only inside the vertical blanking window. Draw modules downstream therefore see parameters that never change mid-frame. It sits between game logic and the draw pipeline and consumes the `vblnk`/`vcount` outputs of the VGA timing generator.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, width of one update word
- MAX_UPD, 8, maximum grants per frame (1..255)
- VL_TOTAL, 628, total lines per frame
- GUARD_LINES, 2, lines before frame end during which no grant is issued (used only with the guard macro)

Ports:
- One clock (`clk`); reset `rst` is synchronous and active-high.
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from the timing generator
- vcount  in  11  current line from the timing generator
- req  in  N_REQ  update request, one per requester; held until ack
- req_data  in  N_REQ*DATA_W  packed update words; requester i occupies bits [i*DATA_W +: DATA_W]; held stable while req[i]
- ack  out  N_REQ  one-cycle grant pulse to the winning requester
- upd_valid  out  1  one-cycle pulse: upd_id/upd_data valid
- upd_id  out  $clog2(N_REQ)  index of the granted requester
- upd_data  out  DATA_W  copy of the granted requester's word
- window_open  out  1  high while in state GRANT
- frame_start  out  1  one-cycle pulse on the vblnk falling edge

## Operation
- Registers: state, vblnk_q (previous vblnk), rr_ptr, budget (8 bit), plus all outputs.
- States and transitions:
  - ACTIVE → GRANT on vblnk rising edge (vblnk=1, vblnk_q=0). budget loads MAX_UPD.
  - GRANT → ACTIVE when vblnk=0. This has priority: no grant is issued that cycle.
  - GRANT → HOLD when a grant takes budget to 0, or when the guard condition holds (see Configuration).
  - HOLD → ACTIVE when vblnk=0.
- Arbitration in GRANT, each cycle when budget>0:
  - Eligible set = req & ~ack. A requester whose ack is currently high is masked, so it cannot be granted twice.
  - The winner is the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - When a winner exists, the next edge registers: ack[winner]=1, upd_valid=1, upd_id=winner, upd_data=req_data[winner]. budget decrements and rr_ptr = (winner+1) mod N_REQ.
  - With no eligible requester, ack/upd_valid are 0 and budget and rr_ptr are unchanged.
- ack, upd_valid and frame_start are pulses. They are 0 in every cycle where no event is registered. upd_id/upd_data hold their last value.
- Pending requests are never dropped. Requests outside the window, or beyond the budget, wait for the next frame.
- frame_start = registered (vblnk_q & ~vblnk). It is issued in every state.

## Timing
- Reset values:
  - state ACTIVE, rr_ptr 0, budget 0, vblnk_q 1 (so vblnk high at reset release is not an edge).
  - ack 0, upd_valid 0, upd_id 0, upd_data 0, window_open 0, frame_start 0.
- Reset asserted mid-window aborts the window. No further grants occur until the next vblnk rising edge.
- Latency:
  - vblnk rising at edge k → window_open=1 after edge k+1.
  - The first grant (ack/upd_valid) is registered at edge k+2 at the earliest.
  - req sampled at edge n → ack at edge n+1.
- Throughput: one grant per cycle. A single requester re-asserting back-to-back is granted at most every other cycle, because of ack masking.
- The requester drops req, or presents new data, in the cycle it sees ack=1.
- req and vblnk fall in the same cycle → no grant; the request stays pending.

## Configuration
- UPDATE_GUARD_EN defined:
  - In GRANT, if vcount >= VL_TOTAL-GUARD_LINES, no grant is issued and the next state is HOLD.
  - This guarantees every update lands at least GUARD_LINES lines before line 0.
- UPDATE_GUARD_EN undefined:
  - No vcount comparison; vcount is unused.
  - Grants continue until vblnk falls or the budget is exhausted.

## Test plan
- Single request: req=4'b0001, req_data[0]=16'hABCD held from active video → no ack before vblnk. ack[0]=1, upd_id=0, upd_data=16'hABCD exactly 2 cycles after the vblnk rising edge; frame_start pulses once on the following vblnk fall.
- Round-robin: req=4'b1111, held high (re-asserted after ack), MAX_UPD=8 → grant order 0,1,2,3,0,1,2,3, then HOLD with window_open=0, and no further ack that frame.
- Budget carry-over: MAX_UPD=2, req=4'b0111 → grants 0,1 in frame N. Requester 2 gets the first grant in frame N+1, since rr_ptr=2.
- Mid-window abort: rst pulsed for 1 cycle during GRANT → all outputs 0, and no ack until the next vblnk rising edge.
- Guard (UPDATE_GUARD_EN, VL_TOTAL=628, GUARD_LINES=2): req held, vcount driven to 626 during GRANT → no ack from that cycle on, state HOLD. Without the macro, grants continue at vcount=626/627.
- Reset release with vblnk=1 → no window opens until vblnk goes 0 and then returns to 1.
